// File: rtl/infifo_dispatch_pkg.sv
// Shared types and default sizing for the input-FIFO dispatcher.
package infifo_pkg;

   localparam int unsigned NUM_THREADS_DEFAULT    = 8;
   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

   // Per-thread ownership: free, being filled by upstream, or owned by the CPU.
   typedef enum logic [1:0] {
      StFree = 2'd0,
      StFill = 2'd1,
      StCpu  = 2'd2
   } thread_state_e;

endpackage

// File: rtl/infifo_dispatch_if.sv
// Handshake bundle between the packet source / CPU side and the dispatcher.
interface infifo_dispatch_if import infifo_pkg::*; #(
   parameter int unsigned NUM_THREADS = NUM_THREADS_DEFAULT,
   localparam int unsigned SEL_W = $clog2(NUM_THREADS)
) ();

   logic                   firstword_in;
   logic                   fifowrite_in;
   logic                   enable_cpu_in;
   logic [NUM_THREADS-1:0] fifo_done;
   logic [NUM_THREADS-1:0] firstword_out;
   logic [NUM_THREADS-1:0] fifowrite_out;
   logic [NUM_THREADS-1:0] enable_cpu_out;
   logic [SEL_W-1:0]       cur_thread;
   logic                   cur_valid;
   logic                   stop_smallfifo_read;
   logic [NUM_THREADS-1:0] busy_vec;
   logic [NUM_THREADS-1:0] timeout_vec;

   // Dispatcher side.
   modport slave (
      input  firstword_in, fifowrite_in, enable_cpu_in, fifo_done,
      output firstword_out, fifowrite_out, enable_cpu_out, cur_thread, cur_valid,
             stop_smallfifo_read, busy_vec, timeout_vec
   );

   // Packet source / CPU side.
   modport master (
      output firstword_in, fifowrite_in, enable_cpu_in, fifo_done,
      input  firstword_out, fifowrite_out, enable_cpu_out, cur_thread, cur_valid,
             stop_smallfifo_read, busy_vec, timeout_vec
   );

endinterface

// File: rtl/infifo_dispatch_rr_pick.sv
// Round-robin picker: first requester strictly after last_grant, wrapping around.
module rr_pick #(
   parameter int unsigned NUM_THREADS = 8,
   localparam int unsigned SEL_W = $clog2(NUM_THREADS)
) (
   input  logic [NUM_THREADS-1:0] req,
   input  logic [SEL_W-1:0]       last_grant,
   output logic [SEL_W-1:0]       winner,
   output logic                   found
);

   logic [SEL_W-1:0] idx;

   // Scan farthest-to-nearest so the nearest requester past last_grant overwrites last.
   // Index arithmetic wraps for free because NUM_THREADS is a power of two.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = NUM_THREADS; k >= 1; k--) begin
         idx = last_grant + SEL_W'(k);
         if (req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/infifo_dispatch.sv
// Routes one incoming packet at a time to a free per-thread input FIFO and tracks each
// thread through FREE -> FILL -> CPU -> FREE. Optional CPU-ownership watchdog is built
// when INFIFO_DISPATCH_TIMEOUT_EN is defined; otherwise timeout_vec is tied low.
module infifo_dispatch import infifo_pkg::*; #(
   parameter int unsigned NUM_THREADS    = NUM_THREADS_DEFAULT,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   localparam int unsigned SEL_W = $clog2(NUM_THREADS)
) (
   input logic             clk,
   input logic             reset,
   infifo_dispatch_if.slave bus
);

   if (NUM_THREADS < 2 || NUM_THREADS > 32 || (NUM_THREADS & (NUM_THREADS - 1)) != 0)
   begin : g_bad_threads
      $error("NUM_THREADS must be a power of two in 2..32");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef INFIFO_DISPATCH_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
`endif

   logic                   cur_valid_q, cur_valid_d;
   logic [SEL_W-1:0]       cur_thread_q, cur_thread_d;
   logic [SEL_W-1:0]       last_grant_q, last_grant_d;
   logic [NUM_THREADS-1:0] fw_route, wr_route, en_route;
   logic [NUM_THREADS-1:0] free_next, busy_int, tmo_int;
   logic [SEL_W-1:0]       rr_winner;
   logic                   rr_found;

   // Steer the packet strobes to the allocated thread; drop everything when unallocated.
   always_comb begin
      fw_route = '0;
      wr_route = '0;
      en_route = '0;
      if (cur_valid_q) begin
         fw_route[cur_thread_q] = bus.firstword_in;
         wr_route[cur_thread_q] = bus.fifowrite_in;
         en_route[cur_thread_q] = bus.enable_cpu_in;
      end
   end

   for (genvar i = 0; i < NUM_THREADS; i++) begin : g_thread
      thread_state_e state_q, state_d;
      logic          expire;

`ifdef INFIFO_DISPATCH_TIMEOUT_EN
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             tmo_q, tmo_d;

      // Last permitted CPU cycle is the one where the count has reached TIMEOUT_CYCLES-1.
      assign expire = (state_q == StCpu) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      // A simultaneous fifo_done is a normal release, so no pulse.
      assign tmo_d  = expire && !bus.fifo_done[i];

      // Count cycles spent in CPU; zero whenever the thread is not staying in CPU.
      always_comb begin
         cnt_d = '0;
         if (state_q == StCpu && state_d == StCpu) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Watchdog counter and release pulse registers.
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
         end
      end

      assign tmo_int[i] = tmo_q;
`else
      assign expire     = 1'b0;
      assign tmo_int[i] = 1'b0;
`endif

      // Thread ownership next state from the routed strobes and CPU release.
      always_comb begin
         state_d = state_q;
         unique case (state_q)
            StFree: if (fw_route[i]) state_d = en_route[i] ? StCpu : StFill;
            StFill: if (en_route[i]) state_d = StCpu;
            StCpu:  if (bus.fifo_done[i] || expire) state_d = StFree;
            default: state_d = StFree;
         endcase
      end

      // Thread ownership register.
      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= StFree;
         end else begin
            state_q <= state_d;
         end
      end

      assign busy_int[i]  = (state_q != StFree);
      // Threads released this cycle are already offered to the picker.
      assign free_next[i] = (state_d == StFree);
   end

   rr_pick #(
      .NUM_THREADS(NUM_THREADS)
   ) u_rr_pick (
      .req       (free_next),
      .last_grant(last_grant_q),
      .winner    (rr_winner),
      .found     (rr_found)
   );

   // Allocation: hand-off closes the current slot; an empty slot takes the RR winner.
   always_comb begin
      cur_valid_d  = cur_valid_q;
      cur_thread_d = cur_thread_q;
      last_grant_d = last_grant_q;
      if (cur_valid_q) begin
         if (bus.enable_cpu_in) cur_valid_d = 1'b0;
      end else if (rr_found) begin
         cur_valid_d  = 1'b1;
         cur_thread_d = rr_winner;
         last_grant_d = rr_winner;
      end
   end

   // Allocation registers; last_grant starts at the top so thread 0 wins first.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_valid_q  <= 1'b0;
         cur_thread_q <= '0;
         last_grant_q <= SEL_W'(NUM_THREADS - 1);
      end else begin
         cur_valid_q  <= cur_valid_d;
         cur_thread_q <= cur_thread_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign bus.firstword_out       = fw_route;
   assign bus.fifowrite_out       = wr_route;
   assign bus.enable_cpu_out      = en_route;
   assign bus.cur_thread          = cur_thread_q;
   assign bus.cur_valid           = cur_valid_q;
   assign bus.stop_smallfifo_read = ~cur_valid_q;
   assign bus.busy_vec            = busy_int;
   assign bus.timeout_vec         = tmo_int;

endmodule

// File: tb/tb_infifo_dispatch.sv
// Self-checking bench for infifo_dispatch: directed scenarios plus random traffic,
// every cycle compared against a behavioural ownership model.
module tb_infifo_dispatch;

   localparam int unsigned N   = 8;
   localparam int unsigned TMO = 16;
`ifdef INFIFO_DISPATCH_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   infifo_dispatch_if #(.NUM_THREADS(N)) bus ();

   infifo_dispatch #(
      .NUM_THREADS   (N),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Model: 0 = free, 1 = filling, 2 = CPU-owned; age = cycles spent CPU-owned so far.
   int             m_state[N];
   int             m_age[N];
   bit             m_valid;
   int             m_thr;
   int             m_last;
   logic [N-1:0]   m_tmo;
   int             wr_cnt[N];
   int             last_thr;

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_state[i] = 0;
         m_age[i]   = 0;
      end
      m_valid = 1'b0;
      m_thr   = 0;
      m_last  = N - 1;
      m_tmo   = '0;
   endtask

   // One clock: apply inputs, compare outputs, advance model, cross the edge.
   task automatic cycle(input bit fw, input bit wr, input bit en, input logic [N-1:0] done);
      logic [N-1:0] efw, ewr, een, ebusy, ntmo;
      int           nstate[N];
      int           nage[N];
      bit           nvalid;
      int           nthr, nlast;
      bus.firstword_in  = fw;
      bus.fifowrite_in  = wr;
      bus.enable_cpu_in = en;
      bus.fifo_done     = done;
      #1;
      efw = '0; ewr = '0; een = '0;
      if (m_valid) begin
         efw[m_thr] = fw;
         ewr[m_thr] = wr;
         een[m_thr] = en;
      end
      for (int i = 0; i < N; i++) ebusy[i] = (m_state[i] != 0);
      chk("firstword_out", bus.firstword_out, efw);
      chk("fifowrite_out", bus.fifowrite_out, ewr);
      chk("enable_cpu_out", bus.enable_cpu_out, een);
      chk("cur_valid", bus.cur_valid, m_valid);
      chk("cur_thread", bus.cur_thread, m_thr);
      chk("stop_read", bus.stop_smallfifo_read, !m_valid);
      chk("busy_vec", bus.busy_vec, ebusy);
      chk("timeout_vec", bus.timeout_vec, m_tmo);
      for (int i = 0; i < N; i++) if (bus.fifowrite_out[i]) wr_cnt[i]++;

      ntmo = '0;
      for (int i = 0; i < N; i++) begin
         nstate[i] = m_state[i];
         nage[i]   = 0;
         if (m_state[i] == 0 && efw[i]) nstate[i] = een[i] ? 2 : 1;
         else if (m_state[i] == 1 && een[i]) nstate[i] = 2;
         else if (m_state[i] == 2) begin
            if (done[i]) nstate[i] = 0;
            else if (TMO_EN && m_age[i] >= TMO) begin
               nstate[i] = 0;
               ntmo[i]   = 1'b1;
            end
         end
         if (nstate[i] == 2) nage[i] = (m_state[i] == 2) ? m_age[i] + 1 : 1;
      end
      nvalid = m_valid;
      nthr   = m_thr;
      nlast  = m_last;
      if (m_valid) begin
         if (en) nvalid = 1'b0;
      end else begin
         for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (!nvalid && nstate[idx] == 0) begin
               nvalid = 1'b1;
               nthr   = idx;
               nlast  = idx;
            end
         end
      end

      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         m_state[i] = nstate[i];
         m_age[i]   = nage[i];
      end
      m_valid = nvalid;
      m_thr   = nthr;
      m_last  = nlast;
      m_tmo   = ntmo;
   endtask

   // Reset with busy inputs held high: everything routed must still be zero.
   task automatic do_reset();
      reset = 1'b1;
      bus.firstword_in  = 1'b1;
      bus.fifowrite_in  = 1'b1;
      bus.enable_cpu_in = 1'b1;
      bus.fifo_done     = '1;
      @(posedge clk);
      #1;
      model_reset();
      chk("rst_firstword_out", bus.firstword_out, '0);
      chk("rst_fifowrite_out", bus.fifowrite_out, '0);
      chk("rst_enable_cpu_out", bus.enable_cpu_out, '0);
      chk("rst_cur_valid", bus.cur_valid, 1'b0);
      chk("rst_cur_thread", bus.cur_thread, '0);
      chk("rst_stop_read", bus.stop_smallfifo_read, 1'b1);
      chk("rst_busy_vec", bus.busy_vec, '0);
      chk("rst_timeout_vec", bus.timeout_vec, '0);
      reset = 1'b0;
   endtask

   task automatic wait_grant();
      int guard = 0;
      while (!m_valid && guard < 64) begin
         cycle(1'b0, 1'b0, 1'b0, '0);
         guard++;
      end
      chk("grant_wait", bus.cur_valid, 1'b1);
   endtask

   task automatic packet(input int words, input bit give_done);
      int           t;
      logic [N-1:0] one;
      wait_grant();
      last_thr = bus.cur_thread;
      t = m_thr;
      for (int w = 0; w < words; w++) cycle(w == 0, 1'b1, w == words - 1, '0);
      if (give_done) begin
         one = 1;
         cycle(1'b0, 1'b0, 1'b0, one << t);
      end
   endtask

   initial begin
      int           k;
      logic         seen;
      logic [N-1:0] d;

      do_reset();

      // Three 4-word packets with immediate release still rotate 0,1,2.
      for (int i = 0; i < N; i++) wr_cnt[i] = 0;
      for (int p = 0; p < 3; p++) begin
         packet(4, 1'b1);
         chk("rr_grant", last_thr, p);
      end
      for (int i = 0; i < 4; i++) chk("wr_pulses", wr_cnt[i], (i < 3) ? 4 : 0);

      // All threads taken: allocation stalls until fifo_done[5].
      do_reset();
      for (int p = 0; p < N; p++) packet(2, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b0, '0);
      chk("full_busy", bus.busy_vec, 8'hFF);
      chk("full_valid", bus.cur_valid, 1'b0);
      chk("full_stop", bus.stop_smallfifo_read, 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h20);
      chk("refill_valid", bus.cur_valid, 1'b1);
      chk("refill_thread", bus.cur_thread, 5);

      // Single-word packet goes straight to CPU, releasable by fifo_done.
      do_reset();
      wait_grant();
      cycle(1'b1, 1'b1, 1'b1, '0);
      chk("single_busy0", bus.busy_vec[0], 1'b1);
      cycle(1'b0, 1'b0, 1'b0, 8'h01);
      chk("single_freed0", bus.busy_vec[0], 1'b0);

      // fifo_done while filling is ignored.
      do_reset();
      for (int p = 0; p < 3; p++) packet(2, 1'b0);
      wait_grant();
      chk("fill_thread3", bus.cur_thread, 3);
      cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b0, 1'b1, 1'b0, 8'h08);
      chk("fill_done_ignored", bus.busy_vec[3], 1'b1);
      cycle(1'b0, 1'b1, 1'b1, '0);
      cycle(1'b0, 1'b0, 1'b0, 8'h08);
      chk("cpu_done_frees", bus.busy_vec[3], 1'b0);

      // Reset mid-packet on thread 2 abandons it; next grant is thread 0.
      do_reset();
      packet(2, 1'b0);
      packet(2, 1'b0);
      wait_grant();
      chk("mid_thread2", bus.cur_thread, 2);
      cycle(1'b1, 1'b1, 1'b0, '0);
      do_reset();
      cycle(1'b0, 1'b0, 1'b0, '0);
      chk("post_rst_valid", bus.cur_valid, 1'b1);
      chk("post_rst_thread", bus.cur_thread, 0);

`ifdef INFIFO_DISPATCH_TIMEOUT_EN
      // Watchdog: release pulse 16 cycles after entering CPU.
      do_reset();
      packet(1, 1'b0);
      k = 0;
      while (bus.timeout_vec[0] !== 1'b1 && k < 40) begin
         cycle(1'b0, 1'b0, 1'b0, '0);
         k++;
      end
      chk("tmo_delay", k, TMO);
      chk("tmo_busy0", bus.busy_vec[0], 1'b0);
      // fifo_done on the last permitted cycle wins: no pulse.
      do_reset();
      packet(1, 1'b0);
      for (int i = 0; i < TMO - 1; i++) cycle(1'b0, 1'b0, 1'b0, '0);
      cycle(1'b0, 1'b0, 1'b0, 8'h01);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         seen = seen | bus.timeout_vec[0];
         cycle(1'b0, 1'b0, 1'b0, '0);
      end
      chk("tmo_done_wins", seen, 1'b0);
      chk("tmo_done_busy0", bus.busy_vec[0], 1'b0);
`endif

      // Random traffic against the model.
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         d = N'($urandom & $urandom & $urandom);
         cycle(($urandom % 4) == 0, ($urandom % 2) == 0, ($urandom % 6) == 0, d);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
